uart_frame_ctrl: RTL and testbench

Command-frame controller that sits between the UART byte receiver and transmitter and the register/config logic. It parses fixed 5-byte command frames from the RX byte stream and executes register writes, register reads or baud-rate changes. It then sequences a 5-byte response through the byte transmitter. It owns the shared baud_set configuration for both UART byte engines.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_frame_timeout.sv | 26 ++
 rtl/uart_frame_ctrl.sv | 156 +++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and helpers for the UART command-frame controller.
package uart_pkg;

    localparam logic [7:0] HEADER    = 8'hA5;
    localparam logic [7:0] CMD_WR    = 8'h01;
    localparam logic [7:0] CMD_RD    = 8'h02;
    localparam logic [7:0] CMD_BAUD  = 8'h03;
    localparam logic [7:0] ST_OK     = 8'h00;
    localparam logic [7:0] ST_BADCHK = 8'h01;
    localparam logic [7:0] ST_BADCMD = 8'h02;

    localparam int unsigned RESP_LEN = 5;

    typedef enum logic [3:0] {
        IDLE,
        GET_CMD,
        GET_ADDR,
        GET_DATA,
        GET_CHK,
        EXEC,
        RD_WAIT,
        TX_LOAD,
        TX_WAIT
    } frame_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte timeout: counts enabled cycles since the last clear and flags expiry.
module uart_frame_timeout
    import uart_pkg::*;
#(
    parameter logic [19:0] TIMEOUT_CYC = 20'd500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [19:0] cnt;

    assign expire = en && (cnt >= TIMEOUT_CYC);

    always_ff @(posedge clk) begin
        if (rst || clr || expire) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 20'd1;
        end
    end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Parses 5-byte command frames, executes register/baud commands and sequences
// the 5-byte response through the byte transmitter.
module uart_frame_ctrl
    import uart_pkg::*;
#(
    parameter logic [7:0]  HEADER      = uart_pkg::HEADER,
    parameter logic [19:0] TIMEOUT_CYC = 20'd500000,
    parameter logic [3:0]  BAUD_RST    = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [7:0] tx_data,
    output logic       send_en,
    input  logic       tx_done,
    output logic [3:0] baud_set,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic [7:0] err_cnt
);

    frame_state_t state, state_nxt;

    logic [7:0] cmd_q, addr_q, data_q, chk_q, status_q, rdata_q, err_q;
    logic [2:0] idx_q;
    logic [3:0] baud_stage_q;
    logic       baud_pend_q;
    logic       in_get, to_expire, last_byte, err_evt;
    logic [7:0] exec_status, resp_byte;

    assign in_get    = state inside {GET_CMD, GET_ADDR, GET_DATA, GET_CHK};
    assign last_byte = (idx_q == 3'(RESP_LEN - 1));
    assign reg_addr  = addr_q;
    assign reg_wdata = data_q;
    assign err_cnt   = err_q;

    uart_frame_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (rx_done),
        .en     (in_get),
        .expire (to_expire)
    );

    // Checksum errors take precedence over an unknown command code.
    always_comb begin
        exec_status = ST_OK;
        if (chk_q != (cmd_q ^ addr_q ^ data_q)) begin
            exec_status = ST_BADCHK;
        end else if (!(cmd_q inside {CMD_WR, CMD_RD, CMD_BAUD})) begin
            exec_status = ST_BADCMD;
        end
    end

    always_comb begin
        case (idx_q)
            3'd0:    resp_byte = HEADER;
            3'd1:    resp_byte = status_q;
            3'd2:    resp_byte = addr_q;
            3'd3:    resp_byte = rdata_q;
            default: resp_byte = status_q ^ addr_q ^ rdata_q;
        endcase
    end

    assign err_evt = ((state == EXEC) && (exec_status != ST_OK)) ||
                     (in_get && !rx_done && to_expire);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        send_en   = 1'b0;
        reg_wr_en = 1'b0;
        reg_rd_en = 1'b0;
        tx_data   = '0;
        case (state)
            IDLE:     if (rx_done && rx_data == HEADER) state_nxt = GET_CMD;
            GET_CMD:  if (rx_done) state_nxt = GET_ADDR; else if (to_expire) state_nxt = IDLE;
            GET_ADDR: if (rx_done) state_nxt = GET_DATA; else if (to_expire) state_nxt = IDLE;
            GET_DATA: if (rx_done) state_nxt = GET_CHK;  else if (to_expire) state_nxt = IDLE;
            GET_CHK:  if (rx_done) state_nxt = EXEC;     else if (to_expire) state_nxt = IDLE;
            EXEC: begin
                reg_wr_en = (exec_status == ST_OK) && (cmd_q == CMD_WR);
                reg_rd_en = (exec_status == ST_OK) && (cmd_q == CMD_RD);
                state_nxt = reg_rd_en ? RD_WAIT : TX_LOAD;
            end
            RD_WAIT:  state_nxt = TX_LOAD;
            TX_LOAD: begin
                send_en   = 1'b1;
                tx_data   = resp_byte;
                state_nxt = TX_WAIT;
            end
            TX_WAIT: begin
                tx_data = resp_byte;
                if (tx_done) state_nxt = last_byte ? IDLE : TX_LOAD;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            chk_q        <= '0;
            status_q     <= '0;
            rdata_q      <= '0;
            idx_q        <= '0;
            baud_stage_q <= '0;
            baud_pend_q  <= 1'b0;
            baud_set     <= BAUD_RST;
            err_q        <= '0;
        end else begin
            case (state)
                GET_CMD:  if (rx_done) cmd_q  <= rx_data;
                GET_ADDR: if (rx_done) addr_q <= rx_data;
                GET_DATA: if (rx_done) data_q <= rx_data;
                GET_CHK:  if (rx_done) chk_q  <= rx_data;
                EXEC: begin
                    status_q <= exec_status;
                    rdata_q  <= data_q;
                    idx_q    <= '0;
                    if (exec_status == ST_OK && cmd_q == CMD_BAUD) begin
                        baud_stage_q <= data_q[3:0];
                        baud_pend_q  <= 1'b1;
                    end
                end
                RD_WAIT:  rdata_q <= reg_rdata;
                TX_WAIT: begin
                    if (tx_done) begin
                        idx_q <= idx_q + 3'd1;
                        // Baud switches only once the whole response has left at the old rate.
                        if (last_byte && baud_pend_q) begin
                            baud_set    <= baud_stage_q;
                            baud_pend_q <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
            if (err_evt) err_q <= sat_inc8(err_q);
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Scoreboard bench for uart_frame_ctrl: randomized frames against a frame-level reference model.
module tb_uart_frame_ctrl;
    import uart_pkg::*;

    localparam logic [19:0] TO_CYC = 20'd64;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] tx_data;
    logic       send_en;
    logic       tx_done;
    logic [3:0] baud_set;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    uart_frame_ctrl #(
        .HEADER      (8'hA5),
        .TIMEOUT_CYC (TO_CYC),
        .BAUD_RST    (4'd0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .tx_data   (tx_data),
        .send_en   (send_en),
        .tx_done   (tx_done),
        .baud_set  (baud_set),
        .reg_wr_en (reg_wr_en),
        .reg_rd_en (reg_rd_en),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .err_cnt   (err_cnt)
    );

    typedef struct packed {
        logic [7:0] b;
        logic [3:0] baud;
    } tx_exp_t;

    tx_exp_t     exp_tx[$];
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  ref_mem[256];
    logic [7:0]  env_mem[256];
    logic [3:0]  ref_baud;
    logic [7:0]  ref_err;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          tx_busy;
    int          tx_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every DUT-presented strobe pops its expectation.
    always @(negedge clk) begin
        if (reg_wr_en) begin
            if (exp_wr.size() == 0) check("wr_unexpected", {31'd0, reg_wr_en}, 32'd0);
            else begin
                logic [15:0] e;
                e = exp_wr.pop_front();
                check("wr_addr", {24'd0, reg_addr}, {24'd0, e[15:8]});
                check("wr_data", {24'd0, reg_wdata}, {24'd0, e[7:0]});
            end
            env_mem[reg_addr] = reg_wdata;
        end
        if (reg_rd_en) begin
            if (exp_rd.size() == 0) check("rd_unexpected", {31'd0, reg_rd_en}, 32'd0);
            else check("rd_addr", {24'd0, reg_addr}, {24'd0, exp_rd.pop_front()});
        end
        if (send_en) begin
            if (exp_tx.size() == 0) check("tx_unexpected", {31'd0, send_en}, 32'd0);
            else begin
                tx_exp_t t;
                t = exp_tx.pop_front();
                check("tx_byte", {24'd0, tx_data}, {24'd0, t.b});
                check("tx_baud", {28'd0, baud_set}, {28'd0, t.baud});
            end
        end
    end

    // Register block model: read data valid exactly one cycle after the strobe, junk otherwise.
    initial begin
        logic [7:0] a;
        reg_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (reg_rd_en) begin
                a = reg_addr;
                @(posedge clk); #1 reg_rdata = env_mem[a];
                @(posedge clk); #1 reg_rdata = 8'($urandom);
            end
        end
    end

    // Byte transmitter model with random completion latency.
    initial begin
        tx_done = 1'b0;
        tx_busy = 1'b0;
        tx_cnt  = 0;
        forever begin
            @(negedge clk);
            if (send_en) begin
                tx_busy = 1'b1;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1 tx_done = 1'b1;
                tx_cnt++;
                @(posedge clk); #1 tx_done = 1'b0;
                tx_busy = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1 rx_data = b; rx_done = 1'b1;
        @(posedge clk); #1 rx_done = 1'b0; rx_data = 8'($urandom);
        repeat ($urandom_range(0, 6)) @(posedge clk);
    endtask

    // Reference model: derives status, side effects and response from the frame rules.
    task automatic model_frame(input logic [7:0] cmd, addr, data, chk, output logic [3:0] new_baud);
        logic [7:0] status, rdata;
        logic [7:0] resp[5];
        status   = (chk != (cmd ^ addr ^ data)) ? ST_BADCHK :
                   (cmd inside {CMD_WR, CMD_RD, CMD_BAUD}) ? ST_OK : ST_BADCMD;
        rdata    = data;
        new_baud = ref_baud;
        if (status == ST_OK) begin
            if (cmd == CMD_WR) begin
                exp_wr.push_back({addr, data});
                ref_mem[addr] = data;
            end else if (cmd == CMD_RD) begin
                exp_rd.push_back(addr);
                rdata = ref_mem[addr];
            end else begin
                new_baud = data[3:0];
            end
        end else if (ref_err != 8'hFF) begin
            ref_err++;
        end
        resp = '{HEADER, status, addr, rdata, status ^ addr ^ rdata};
        foreach (resp[i]) exp_tx.push_back('{b: resp[i], baud: ref_baud});
    endtask

    task automatic send_frame(input logic [7:0] cmd, addr, data, chk);
        send_byte(HEADER);
        send_byte(cmd);
        send_byte(addr);
        send_byte(data);
        send_byte(chk);
    endtask

    task automatic run_frame(input logic [7:0] cmd, addr, data, chk);
        logic [3:0] nb;
        int k;
        model_frame(cmd, addr, data, chk, nb);
        send_frame(cmd, addr, data, chk);
        k = 0;
        while ((exp_tx.size() != 0 || tx_busy || exp_wr.size() != 0 || exp_rd.size() != 0) && k < 3000) begin
            @(posedge clk);
            k++;
        end
        check("resp_pending", exp_tx.size(), 32'd0);
        exp_tx.delete(); exp_wr.delete(); exp_rd.delete();
        repeat (3) @(posedge clk);
        #1;
        ref_baud = nb;
        check("err_cnt", {24'd0, err_cnt}, {24'd0, ref_err});
        check("baud_set", {28'd0, baud_set}, {28'd0, ref_baud});
    endtask

    task automatic check_reset_outputs();
        check("rst_send_en",   {31'd0, send_en},   32'd0);
        check("rst_reg_wr_en", {31'd0, reg_wr_en}, 32'd0);
        check("rst_reg_rd_en", {31'd0, reg_rd_en}, 32'd0);
        check("rst_tx_data",   {24'd0, tx_data},   32'd0);
        check("rst_reg_addr",  {24'd0, reg_addr},  32'd0);
        check("rst_reg_wdata", {24'd0, reg_wdata}, 32'd0);
        check("rst_baud_set",  {28'd0, baud_set},  32'd0);
        check("rst_err_cnt",   {24'd0, err_cnt},   32'd0);
    endtask

    initial begin
        logic [7:0] cmd, addr, data, chk, noise;
        int base, k;
        rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00;
        ref_baud = 4'd0; ref_err = 8'd0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'($urandom);
            env_mem[i] = ref_mem[i];
        end
        ref_mem[8'h22] = 8'h7E;
        env_mem[8'h22] = 8'h7E;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1 rst = 1'b0;

        run_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
        run_frame(8'h02, 8'h22, 8'h00, 8'h20);
        run_frame(8'h01, 8'h10, 8'h3C, 8'h00);
        run_frame(8'h03, 8'h00, 8'h05, 8'h06);
        run_frame(8'h09, 8'h00, 8'h00, 8'h09);

        // Noise byte, then a frame that stalls after CMD until the timeout fires.
        send_byte(8'h3F);
        send_byte(HEADER);
        send_byte(8'h01);
        repeat (int'(TO_CYC) + 20) @(posedge clk);
        #1;
        if (ref_err != 8'hFF) ref_err++;
        check("timeout_err_cnt", {24'd0, err_cnt}, {24'd0, ref_err});
        run_frame(8'h01, 8'h33, 8'hC4, 8'h01 ^ 8'h33 ^ 8'hC4);

        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 9);
            cmd  = (k < 3) ? CMD_WR : (k < 6) ? CMD_RD : (k < 8) ? CMD_BAUD : 8'($urandom_range(4, 255));
            addr = 8'($urandom);
            data = 8'($urandom);
            chk  = cmd ^ addr ^ data;
            if ($urandom_range(0, 6) == 0) chk = chk ^ 8'($urandom_range(1, 255));
            if ($urandom_range(0, 2) == 0) begin
                noise = 8'($urandom);
                if (noise == HEADER) noise = 8'h5A;
                send_byte(noise);
            end
            run_frame(cmd, addr, data, chk);
        end

        // Reset in the cycle of the 2nd tx_done: no further send_en may follow.
        begin
            logic [3:0] nb;
            model_frame(CMD_WR, 8'h40, 8'h55, CMD_WR ^ 8'h40 ^ 8'h55, nb);
        end
        base = tx_cnt;
        send_frame(CMD_WR, 8'h40, 8'h55, CMD_WR ^ 8'h40 ^ 8'h55);
        for (k = 0; k < 3000; k++) begin
            @(posedge clk); #2;
            if (tx_done && tx_cnt == base + 2) break;
        end
        check("rst_trigger_tx_cnt", tx_cnt, base + 2);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_tx.delete();
        ref_err  = 8'd0;
        ref_baud = 4'd0;
        @(negedge clk);
        check_reset_outputs();
        repeat (30) @(posedge clk);
        check("rst_wr_done", exp_wr.size(), 32'd0);
        run_frame(CMD_RD, 8'h40, 8'h00, CMD_RD ^ 8'h40);
        run_frame(8'h07, 8'h01, 8'h02, 8'h07 ^ 8'h01 ^ 8'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation still running at %0t, limit 5000000", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
